regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter: DATA_W, 32, width of each register.
REQ-002 Parameter: ADDR_W, 5, address width; depth is 2**ADDR_W.
REQ-003 Parameter: ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.
REQ-004 clock  input  1  all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 we0 / waddr0 / wdata0  input  1 / ADDR_W / DATA_W  write port 0.
REQ-007 we1 / waddr1 / wdata1  input  1 / ADDR_W / DATA_W  write port 1; higher priority than port 0.
REQ-008 iss_en / iss_addr  input  1 / ADDR_W  marks a register as pending a future write (scoreboard set).
REQ-009 flush  input  1  synchronous clear of all busy bits.
REQ-010 raddr1 / raddr2  input  ADDR_W  read addresses.
REQ-011 rdata1 / rdata2  output  DATA_W  combinational read data.
REQ-012 busy1 / busy2  output  1  combinational busy bit of raddr1 / raddr2.
REQ-013 busy_cnt  output  ADDR_W+1  registered count of currently set busy bits.

Function
REQ-014 On a rising edge with weN=1, the block SHALL store wdataN into register waddrN.
REQ-015 If we0=we1=1 and waddr0==waddr1, the block SHALL store wdata1 only.
REQ-016 With ZERO_REG=1, writes to address 0 SHALL be dropped and rdata for address 0 SHALL be 0.
REQ-017 Without bypass, rdataN SHALL equal the stored value; a write becomes visible on rdata the cycle after its edge.
REQ-018 On a rising edge with iss_en=1, the block SHALL set busy[iss_addr] (not for address 0 when ZERO_REG=1).
REQ-019 On a rising edge with weN=1, the block SHALL clear busy[waddrN] (even if it was not set).
REQ-020 Same-edge set and clear of one address: set SHALL win (the new issue is the pending writer).
REQ-021 flush=1 SHALL clear every busy bit on that edge, overriding iss_en; register contents are not affected and writes on that edge still occur.
REQ-022 busy_cnt SHALL equal the number of set busy bits after each edge; range 0..2**ADDR_W (2**ADDR_W-1 with ZERO_REG=1); it never wraps.
REQ-023 Read ports SHALL be independent; raddr1==raddr2 returns identical data and busy.

Reset
REQ-024 reset=1 SHALL immediately, without a clock, set all registers to 0, all busy bits to 0 and busy_cnt to 0.
REQ-025 A write, issue or flush coinciding with reset SHALL be discarded; reset asserted mid-operation loses all pending state.
REQ-026 Registers SHALL also initialise to 0 at time zero in simulation.

Configuration
REQ-027 Macro RF_BYPASS_EN: when defined, rdataN SHALL return the same-cycle write data when weN matches raddr (port 1 over port 0, subject to REQ-016), and busyN SHALL read 0 when a same-cycle write clears that address and no iss_en sets it.
REQ-028 Without RF_BYPASS_EN: no bypass paths; read data and busy reflect state as of the last edge only.

Verification
REQ-029 Reset, then read all 32 addresses -> rdata 0, busy 0, busy_cnt 0.
REQ-030 we0=1 waddr0=5 wdata0=0xAAAA0001, we1=1 waddr1=5 wdata1=0x5555_0002 same edge -> register 5 reads 0x55550002.
REQ-031 Write 0xFFFFFFFF to address 0 -> rdata 0; iss_en addr 0 -> busy 0, busy_cnt unchanged.
REQ-032 iss_en addr 7, next edge iss_en addr 9 -> busy_cnt 2; then we1 addr 7 with iss_en addr 7 same edge -> busy[7] stays 1, busy_cnt 2; then flush -> busy_cnt 0.
REQ-033 raddr1=3, we0 waddr0=3 wdata0=0x12345678 before edge -> with RF_BYPASS_EN rdata1=0x12345678 in that cycle; without it rdata1 old value until after edge.
REQ-034 Assert reset asynchronously between edges after writes to 1..31 -> all rdata 0 and busy_cnt 0 before the next edge.

Source files
------------

// File: rtl/regfile_sb.sv
// Two-write, two-read register file with a per-register busy scoreboard and busy count.
// Optional macro RF_BYPASS_EN forwards same-cycle write data and busy clears to the read ports.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  cnt_d;

    // Register 0 is hardwired when ZERO_REG is set.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Storage: port 1 wins a same-address collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (writable(ADDR_W'(i))) begin
                    if (we1 && (waddr1 == ADDR_W'(i)))      mem[i] <= wdata1;
                    else if (we0 && (waddr0 == ADDR_W'(i))) mem[i] <= wdata0;
                end
            end
        end
    end

    // Scoreboard next state: writes clear, issue sets (and wins), flush clears all.
    always_comb begin
        busy_d = busy_q;
        if (we0) busy_d[waddr0] = 1'b0;
        if (we1) busy_d[waddr1] = 1'b0;
        if (iss_en && writable(iss_addr)) busy_d[iss_addr] = 1'b1;
        if (flush) busy_d = '0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q   <= '0;
            busy_cnt <= '0;
        end else begin
            busy_q   <= busy_d;
            busy_cnt <= cnt_d;
        end
    end

`ifdef RF_BYPASS_EN
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = mem[a];
        if (!writable(a))                 v = '0;
        else if (we1 && (waddr1 == a))    v = wdata1;
        else if (we0 && (waddr0 == a))    v = wdata0;
        return v;
    endfunction

    function automatic logic bz(input logic [ADDR_W-1:0] a);
        logic b;
        b = busy_q[a];
        if (((we0 && (waddr0 == a)) || (we1 && (waddr1 == a))) &&
            !(iss_en && (iss_addr == a)))
            b = 1'b0;
        return b;
    endfunction
`else
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        return writable(a) ? mem[a] : '0;
    endfunction

    function automatic logic bz(input logic [ADDR_W-1:0] a);
        return busy_q[a];
    endfunction
`endif

    assign rdata1 = rd(raddr1);
    assign rdata2 = rd(raddr2);
    assign busy1  = bz(raddr1);
    assign busy2  = bz(raddr2);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
module tb_regfile_sb;

    logic        clock = 1'b0;
    logic        reset;
    logic        we0, we1, iss_en, flush;
    logic [4:0]  waddr0, waddr1, iss_addr, raddr1, raddr2;
    logic [31:0] wdata0, wdata1, rdata1, rdata2;
    logic        busy1, busy2;
    logic [5:0]  busy_cnt;

    int checks   = 0;
    int failures = 0;

    regfile_sb dut (
        .clock(clock), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; iss_en = 0; flush = 0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_addr = '0;
    endtask

    // Advance to just after the next rising edge, then drop all request inputs.
    task automatic tick();
        @(posedge clock);
        #1;
        idle();
        #1;
    endtask

    task automatic issue(input logic [4:0] a);
        iss_en = 1; iss_addr = a;
        tick();
    endtask

    logic [31:0] exp_rd;
    logic        exp_bz;

    initial begin
        reset = 1;
        idle();
        raddr1 = '0; raddr2 = '0;
        #1;
        check("time0_cnt", 64'(busy_cnt), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset = 0;
        #1;

        // Post-reset sweep of every address on both ports
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a);
            #1;
            check("rst_rdata1", 64'(rdata1), 64'd0);
            check("rst_rdata2", 64'(rdata2), 64'd0);
            check("rst_busy1",  64'(busy1),  64'd0);
        end
        check("rst_cnt", 64'(busy_cnt), 64'd0);

        // Same-address dual write: port 1 wins
        we0 = 1; waddr0 = 5; wdata0 = 32'hAAAA_0001;
        we1 = 1; waddr1 = 5; wdata1 = 32'h5555_0002;
        tick();
        raddr1 = 5; raddr2 = 5; #1;
        check("collide_rd1", 64'(rdata1), 64'h5555_0002);
        check("collide_rd2", 64'(rdata2), 64'h5555_0002);

        // Independent writes to distinct addresses
        we0 = 1; waddr0 = 11; wdata0 = 32'h0000_0011;
        we1 = 1; waddr1 = 12; wdata1 = 32'h0000_0022;
        tick();
        raddr1 = 11; raddr2 = 12; #1;
        check("dual_wr0", 64'(rdata1), 64'h11);
        check("dual_wr1", 64'(rdata2), 64'h22);

        // Register 0 ignores writes and issues
        we1 = 1; waddr1 = 0; wdata1 = 32'hFFFF_FFFF;
        we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
        tick();
        raddr1 = 0; #1;
        check("zero_rd", 64'(rdata1), 64'd0);
        issue(0);
        check("zero_busy", 64'(busy1), 64'd0);
        check("zero_cnt",  64'(busy_cnt), 64'd0);

        // Scoreboard set, collision with write, clear, flush
        issue(7);
        check("cnt_one", 64'(busy_cnt), 64'd1);
        issue(9);
        raddr1 = 7; raddr2 = 9; #1;
        check("cnt_two", 64'(busy_cnt), 64'd2);
        check("busy7",   64'(busy1), 64'd1);
        check("busy9",   64'(busy2), 64'd1);
        we1 = 1; waddr1 = 7; wdata1 = 32'h77; iss_en = 1; iss_addr = 7;
        tick();
        check("setwins_busy", 64'(busy1), 64'd1);
        check("setwins_cnt",  64'(busy_cnt), 64'd2);
        check("setwins_data", 64'(rdata1), 64'h77);
        we0 = 1; waddr0 = 9; wdata0 = 32'h99;
        tick();
        check("clr9_busy", 64'(busy2), 64'd0);
        check("clr9_cnt",  64'(busy_cnt), 64'd1);
        we0 = 1; waddr0 = 13; wdata0 = 32'h13;
        tick();
        check("clr_unset_cnt", 64'(busy_cnt), 64'd1);
        issue(20);
        check("cnt_two_b", 64'(busy_cnt), 64'd2);
        flush = 1; iss_en = 1; iss_addr = 21; we0 = 1; waddr0 = 22; wdata0 = 32'hCC;
        tick();
        raddr1 = 21; raddr2 = 22; #1;
        check("flush_cnt",   64'(busy_cnt), 64'd0);
        check("flush_iss",   64'(busy1), 64'd0);
        check("flush_write", 64'(rdata2), 64'hCC);
        raddr1 = 7; #1;
        check("flush_keep", 64'(rdata1), 64'h77);

        // Same-cycle visibility of a write (bypass only when enabled)
        issue(3);
        raddr1 = 3;
        we0 = 1; waddr0 = 3; wdata0 = 32'h1234_5678;
        #1;
`ifdef RF_BYPASS_EN
        exp_rd = 32'h1234_5678; exp_bz = 1'b0;
`else
        exp_rd = 32'h0; exp_bz = 1'b1;
`endif
        check("byp_rdata", 64'(rdata1), 64'(exp_rd));
        check("byp_busy",  64'(busy1),  64'(exp_bz));
        tick();
        check("post_rdata", 64'(rdata1), 64'h1234_5678);
        check("post_busy",  64'(busy1),  64'd0);

        // Fill the scoreboard: max count is 31 with register 0 hardwired
        for (int a = 1; a < 32; a++) issue(5'(a));
        check("cnt_full", 64'(busy_cnt), 64'd31);
        issue(17);
        check("cnt_full_hold", 64'(busy_cnt), 64'd31);

        // Write 1..31, then asynchronous reset between edges
        for (int a = 1; a < 32; a += 2) begin
            we0 = 1; waddr0 = 5'(a); wdata0 = 32'h100 + 32'(a);
            if (a < 31) begin
                we1 = 1; waddr1 = 5'(a + 1); wdata1 = 32'h100 + 32'(a + 1);
            end
            tick();
        end
        raddr1 = 1; raddr2 = 31; #1;
        check("fill_rd1",  64'(rdata1), 64'h101);
        check("fill_rd31", 64'(rdata2), 64'h11F);
        issue(4);
        check("pre_rst_cnt", 64'(busy_cnt), 64'd1);
        #1 reset = 1;
        #1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(a);
            #0.01;
            check("arst_rd1", 64'(rdata1), 64'd0);
            check("arst_rd2", 64'(rdata2), 64'd0);
        end
        check("arst_cnt", 64'(busy_cnt), 64'd0);

        // Requests under reset are discarded
        we0 = 1; waddr0 = 4; wdata0 = 32'hDEAD; iss_en = 1; iss_addr = 6;
        tick();
        reset = 0;
        raddr1 = 4; raddr2 = 6; #1;
        check("rst_drop_wr",  64'(rdata1), 64'd0);
        check("rst_drop_iss", 64'(busy2),  64'd0);
        check("rst_drop_cnt", 64'(busy_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
